// File: rtl/sfu_seq.sv
// Sequencer for one sfu_row: streams the psum sweep in, waits for the
// accumulated result, then writes mij_len output rows with optional ReLU.
module sfu_seq #(
    parameter int col      = 8,
    parameter int psum_bw  = 16,
    parameter int kij_len  = 9,
    parameter int nij_len  = 36,
    parameter int mij_len  = 16,
    parameter int addr_bw  = 11,
    parameter int oaddr_bw = 6,
    parameter int wait_max = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            relu_en,
    input  logic [addr_bw-1:0]              psum_base,
    input  logic [oaddr_bw-1:0]             out_base,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic                            psum_ren,
    output logic [addr_bw-1:0]              psum_addr,
    output logic                            sfu_reset,
    output logic                            sfu_i_valid,
    input  logic                            sfu_o_valid,
    input  logic [col*mij_len*psum_bw-1:0]  sfu_out,
    output logic                            out_wen,
    output logic [oaddr_bw-1:0]             out_addr,
    output logic [col*psum_bw-1:0]          out_wdata
);

    localparam int NRD = kij_len * nij_len;
    localparam int CW  = $clog2(NRD);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LOAD, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  tmo_d, tmo_q;
    logic                  relu_q;
    logic [addr_bw-1:0]    base_q;
    logic [oaddr_bw-1:0]   obase_q;
    logic                  busy_q, done_q, err_q;
    logic                  ren_q, ivld_q, wen_q;
    logic [addr_bw-1:0]    addr_q;
    logic [oaddr_bw-1:0]   oaddr_q;
    logic [psum_bw-1:0]    col_v;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) state_d = S_CLR;
            end
            S_CLR: begin
                cnt_d   = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (cnt_q == CW'(NRD - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (sfu_o_valid) begin
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end else if (cnt_q == CW'(wait_max - 1)) begin
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WRITE: begin
                if (cnt_q == CW'(mij_len - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            relu_q  <= 1'b0;
            base_q  <= '0;
            obase_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ren_q   <= 1'b0;
            ivld_q  <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            oaddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            ren_q   <= (state_d == S_LOAD);
            ivld_q  <= ren_q;
            wen_q   <= (state_d == S_WRITE);
            if (state_q == S_IDLE && start) begin
                relu_q  <= relu_en;
                base_q  <= psum_base;
                obase_q <= out_base;
                err_q   <= 1'b0;
            end else if (tmo_d) begin
                err_q <= 1'b1;
            end
            if (state_q == S_CLR)
                addr_q <= base_q;
            else if (state_q == S_LOAD && state_d == S_LOAD)
                addr_q <= addr_q + addr_bw'(1);
            if (state_q != S_WRITE && state_d == S_WRITE)
                oaddr_q <= obase_q;
            else if (state_q == S_WRITE && state_d == S_WRITE)
                oaddr_q <= oaddr_q + oaddr_bw'(1);
        end
    end

    // Row m of the result is picked by the WRITE-phase counter.
    always_comb begin
        out_wdata = '0;
        col_v     = '0;
        if (state_q == S_WRITE) begin
            for (int j = 0; j < col; j++) begin
                col_v = sfu_out[(j * mij_len + int'(cnt_q)) * psum_bw +: psum_bw];
                if (relu_q && col_v[psum_bw-1]) col_v = '0;
                out_wdata[j*psum_bw +: psum_bw] = col_v;
            end
        end
    end

    assign sfu_reset   = reset | (state_q == S_CLR) | tmo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign psum_ren    = ren_q;
    assign psum_addr   = addr_q;
    assign sfu_i_valid = ivld_q;
    assign out_wen     = wen_q;
    assign out_addr    = oaddr_q;

endmodule
